// File: rtl/dnn_pkg.sv
// Shared constants for the dest_reg layer sequencer: lane count, default widths
// and the controller state encoding.
package dnn_pkg;

    localparam int LANES       = 4;
    localparam int DEF_I_WIDTH = 4;
    localparam int DEF_D_WIDTH = 16;
    localparam int DEF_ACC_W   = 2 * DEF_D_WIDTH;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] S_IDLE = 4'd0;
    localparam logic [STATE_W-1:0] S_SET  = 4'd1;
    localparam logic [STATE_W-1:0] S_GAP  = 4'd2;
    localparam logic [STATE_W-1:0] S_ACC  = 4'd3;
    localparam logic [STATE_W-1:0] S_RD   = 4'd4;
    localparam logic [STATE_W-1:0] S_WT   = 4'd5;
    localparam logic [STATE_W-1:0] S_WR   = 4'd6;
    localparam logic [STATE_W-1:0] S_ACT  = 4'd7;
    localparam logic [STATE_W-1:0] S_AGAP = 4'd8;
    localparam logic [STATE_W-1:0] S_RI   = 4'd9;
    localparam logic [STATE_W-1:0] S_RW   = 4'd10;
    localparam logic [STATE_W-1:0] S_RP   = 4'd11;

endpackage

// File: rtl/dest_reg_rmw.sv
// Read-modify-write datapath for one 4-lane partial-sum beat: lane mask,
// per-lane indices, captured psums/raw accumulators and the lane adders.
module dest_reg_rmw
    import dnn_pkg::*;
#(
    parameter int I_WIDTH = DEF_I_WIDTH,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_capture,
    input  logic                              i_raw_capture,
    input  logic [I_WIDTH-1:0]                i_base,
    input  logic [I_WIDTH:0]                  i_n_out,
    input  logic [LANES-1:0][ACC_W-1:0]       i_psum,
    input  logic [LANES-1:0][ACC_W-1:0]       i_raw,
    output logic [LANES-1:0]                  o_mask,
    output logic [LANES-1:0][I_WIDTH-1:0]     o_index,
    output logic [LANES-1:0][ACC_W-1:0]       o_wdata
);

    localparam int IDX_W = I_WIDTH + 1;

    logic [I_WIDTH-1:0]              r_base;
    logic [LANES-1:0][ACC_W-1:0]     r_psum;
    logic [LANES-1:0][ACC_W-1:0]     r_raw;
    logic [LANES-1:0][I_WIDTH:0]     w_lane_idx;

    // Lane position is formed one bit wider so lanes past the file end are masked, not wrapped.
    always_comb begin
        w_lane_idx = '0;
        o_mask     = '0;
        o_index    = '0;
        o_wdata    = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane_idx[k] = {1'b0, r_base} + IDX_W'(k);
            o_mask[k]     = (w_lane_idx[k] < i_n_out);
            o_index[k]    = w_lane_idx[k][I_WIDTH-1:0];
            o_wdata[k]    = r_raw[k] + r_psum[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base <= '0;
            r_psum <= '0;
            r_raw  <= '0;
        end else begin
            if (i_capture) begin
                r_base <= i_base;
                r_psum <= i_psum;
            end
            if (i_raw_capture) begin
                r_raw <= i_raw;
            end
        end
    end

endmodule

// File: rtl/dest_reg_ctrl.sv
// Layer sequencer for the 4-lane accumulator file: bias set, psum RMW beats,
// ReLU pulse, then a handshaked readout of n_out results in index order.
module dest_reg_ctrl
    import dnn_pkg::*;
#(
    parameter int I_WIDTH = DEF_I_WIDTH,
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [I_WIDTH:0]       i_n_out,
    input  logic [D_WIDTH-1:0]     i_bias,
    input  logic                   i_psum_valid,
    output logic                   o_psum_ready,
    input  logic                   i_psum_last,
    input  logic [I_WIDTH-1:0]     i_psum_base,
    input  logic [2*D_WIDTH-1:0]   i_psum0,
    input  logic [2*D_WIDTH-1:0]   i_psum1,
    input  logic [2*D_WIDTH-1:0]   i_psum2,
    input  logic [2*D_WIDTH-1:0]   i_psum3,
    output logic                   o_dr_set,
    output logic                   o_dr_act,
    output logic [D_WIDTH-1:0]     o_dr_bias,
    output logic [I_WIDTH-1:0]     o_dr_index0,
    output logic [I_WIDTH-1:0]     o_dr_index1,
    output logic [I_WIDTH-1:0]     o_dr_index2,
    output logic [I_WIDTH-1:0]     o_dr_index3,
    output logic [3:0]             o_dr_r_raw_en,
    output logic [3:0]             o_dr_w_en,
    output logic [2*D_WIDTH-1:0]   o_dr_wdata0,
    output logic [2*D_WIDTH-1:0]   o_dr_wdata1,
    output logic [2*D_WIDTH-1:0]   o_dr_wdata2,
    output logic [2*D_WIDTH-1:0]   o_dr_wdata3,
    input  logic [2*D_WIDTH-1:0]   i_dr_raw0,
    input  logic [2*D_WIDTH-1:0]   i_dr_raw1,
    input  logic [2*D_WIDTH-1:0]   i_dr_raw2,
    input  logic [2*D_WIDTH-1:0]   i_dr_raw3,
    output logic                   o_dr_r_en,
    output logic [I_WIDTH-1:0]     o_dr_index_rd,
    input  logic [D_WIDTH-1:0]     i_dr_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [D_WIDTH-1:0]     o_out_data,
    output logic [I_WIDTH-1:0]     o_out_index,
    output logic                   o_out_last,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int               ACC_W = 2 * D_WIDTH;
    localparam logic [I_WIDTH:0] DEPTH = {1'b1, {I_WIDTH{1'b0}}};

    logic [STATE_W-1:0]            r_state;
    logic [STATE_W-1:0]            w_next;
    logic [I_WIDTH:0]              r_n_out;
    logic [I_WIDTH:0]              w_n_clamped;
    logic [D_WIDTH-1:0]            r_bias;
    logic [D_WIDTH-1:0]            r_out_data;
    logic [I_WIDTH-1:0]            r_cnt;
    logic                          r_last;
    logic                          r_done;
    logic                          w_beat;
    logic                          w_out_hs;
    logic                          w_cnt_last;
    logic                          w_idx_en;
    logic [LANES-1:0]              w_mask;
    logic [LANES-1:0][I_WIDTH-1:0] w_index;
    logic [LANES-1:0][ACC_W-1:0]   w_wdata;
    logic [LANES-1:0][ACC_W-1:0]   w_psum;
    logic [LANES-1:0][ACC_W-1:0]   w_raw;

    assign w_psum      = {i_psum3, i_psum2, i_psum1, i_psum0};
    assign w_raw       = {i_dr_raw3, i_dr_raw2, i_dr_raw1, i_dr_raw0};
    assign w_n_clamped = ((i_n_out == '0) || (i_n_out > DEPTH)) ? DEPTH : i_n_out;
    assign w_beat      = (r_state == S_ACC) && i_psum_valid;
    assign w_out_hs    = (r_state == S_RP) && i_out_ready;
    assign w_cnt_last  = ({1'b0, r_cnt} == (r_n_out - 1'b1));
    assign w_idx_en    = (r_state == S_RD) || (r_state == S_WT) || (r_state == S_WR);

    dest_reg_rmw #(
        .I_WIDTH (I_WIDTH),
        .ACC_W   (ACC_W)
    ) u_rmw (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_capture     (w_beat),
        .i_raw_capture (r_state == S_WT),
        .i_base        (i_psum_base),
        .i_n_out       (r_n_out),
        .i_psum        (w_psum),
        .i_raw         (w_raw),
        .o_mask        (w_mask),
        .o_index       (w_index),
        .o_wdata       (w_wdata)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_SET;
            S_SET:  w_next = S_GAP;
            S_GAP:  w_next = S_ACC;
            S_ACC:  if (i_psum_valid) w_next = S_RD;
            S_RD:   w_next = S_WT;
            S_WT:   w_next = S_WR;
            S_WR:   w_next = r_last ? S_ACT : S_ACC;
            S_ACT:  w_next = S_AGAP;
            S_AGAP: w_next = S_RI;
            S_RI:   w_next = S_RW;
            S_RW:   w_next = S_RP;
            S_RP:   if (i_out_ready) w_next = w_cnt_last ? S_IDLE : S_RI;
            default: w_next = S_IDLE;
        endcase
    end

    // dest_reg strobes are pure state decodes, so set/act/w_en can never overlap.
    always_comb begin
        o_psum_ready  = (r_state == S_ACC);
        o_dr_set      = (r_state == S_SET);
        o_dr_act      = (r_state == S_ACT);
        o_dr_bias     = r_bias;
        o_dr_r_raw_en = (r_state == S_RD) ? w_mask : 4'b0000;
        o_dr_w_en     = (r_state == S_WR) ? w_mask : 4'b0000;
        o_dr_index0   = w_idx_en ? w_index[0] : '0;
        o_dr_index1   = w_idx_en ? w_index[1] : '0;
        o_dr_index2   = w_idx_en ? w_index[2] : '0;
        o_dr_index3   = w_idx_en ? w_index[3] : '0;
        o_dr_wdata0   = (r_state == S_WR) ? w_wdata[0] : '0;
        o_dr_wdata1   = (r_state == S_WR) ? w_wdata[1] : '0;
        o_dr_wdata2   = (r_state == S_WR) ? w_wdata[2] : '0;
        o_dr_wdata3   = (r_state == S_WR) ? w_wdata[3] : '0;
        o_dr_r_en     = (r_state == S_RI);
        o_dr_index_rd = (r_state == S_RI) ? r_cnt : '0;
        o_out_valid   = (r_state == S_RP);
        o_out_data    = r_out_data;
        o_out_index   = (r_state == S_RP) ? r_cnt : '0;
        o_out_last    = (r_state == S_RP) && w_cnt_last;
        o_busy        = (r_state != S_IDLE);
        o_done        = r_done;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_n_out    <= '0;
            r_bias     <= '0;
            r_cnt      <= '0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_out_hs && w_cnt_last;
            if ((r_state == S_IDLE) && i_start) begin
                r_n_out <= w_n_clamped;
                r_bias  <= i_bias;
            end
            if (w_beat) begin
                r_last <= i_psum_last;
            end
            if (r_state == S_AGAP) begin
                r_cnt <= '0;
            end else if (w_out_hs && !w_cnt_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_RW) begin
                r_out_data <= i_dr_data;
            end
        end
    end

endmodule
